// File: rtl/sr_input_conditioner.sv
// Three-channel switch conditioner: 2-flop sync + per-channel debounce FSM, clean SR/enable decode.
// Optional SRC_STICKY_CONFLICT_EN makes conflict_o latch until reset.
module sr_input_conditioner #(
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [2:0] SW,
  output logic       en_o,
  output logic       set_o,
  output logic       reset_o,
  output logic       en_rise_o,
  output logic       conflict_o,
  output logic       stable_o
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  typedef enum logic {
    STABLE  = 1'b0,
    PENDING = 1'b1
  } state_t;

  logic [2:0] sync1;
  logic [2:0] sync2;
  logic [2:0] clean;
  logic [2:0] pend;
  logic       en_d;
  logic       en_rise;
  logic       all_on;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= SW;
      sync2 <= sync1;
    end
  end

  for (genvar i = 0; i < 3; i++) begin : g_ch
    state_t          state_q;
    logic [CW-1:0]   cnt_q;
    logic            clean_q;

    // A mismatch must persist through the full count; any agreement restarts the wait.
    always_ff @(posedge clk) begin
      if (rst) begin
        state_q <= STABLE;
        cnt_q   <= '0;
        clean_q <= 1'b0;
      end else begin
        case (state_q)
          STABLE: begin
            if (sync2[i] != clean_q) begin
              state_q <= PENDING;
              cnt_q   <= '0;
            end
          end
          PENDING: begin
            if (sync2[i] == clean_q) begin
              state_q <= STABLE;
              cnt_q   <= '0;
            end else if (cnt_q == CNT_LAST) begin
              clean_q <= sync2[i];
              state_q <= STABLE;
              cnt_q   <= '0;
            end else begin
              cnt_q <= cnt_q + 1'b1;
            end
          end
          default: begin
            state_q <= STABLE;
            cnt_q   <= '0;
          end
        endcase
      end
    end

    assign clean[i] = clean_q;
    assign pend[i]  = (state_q == PENDING);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      en_d    <= 1'b0;
      en_rise <= 1'b0;
    end else begin
      en_d    <= clean[2];
      en_rise <= clean[2] & ~en_d;
    end
  end

  assign all_on    = &clean;
  assign en_o      = clean[2];
  assign set_o     = clean[2] & clean[0] & ~clean[1];
  assign reset_o   = clean[2] & clean[1] & ~clean[0];
  assign en_rise_o = en_rise;
  assign stable_o  = ~|pend;

`ifdef SRC_STICKY_CONFLICT_EN
  logic conflict_seen;

  always_ff @(posedge clk) begin
    if (rst) begin
      conflict_seen <= 1'b0;
    end else if (all_on) begin
      conflict_seen <= 1'b1;
    end
  end

  assign conflict_o = conflict_seen | all_on;
`else
  assign conflict_o = all_on;
`endif

endmodule

// File: tb/tb_sr_input_conditioner.sv
// Randomized + directed bench for sr_input_conditioner with a queue-based scoreboard.
module tb_sr_input_conditioner;

  localparam int D = 4;

  logic       clk;
  logic       rst;
  logic [2:0] sw;
  logic       en_o, set_o, reset_o, en_rise_o, conflict_o, stable_o;

  sr_input_conditioner #(.DEBOUNCE_CYCLES(D)) dut (
    .clk       (clk),
    .rst       (rst),
    .SW        (sw),
    .en_o      (en_o),
    .set_o     (set_o),
    .reset_o   (reset_o),
    .en_rise_o (en_rise_o),
    .conflict_o(conflict_o),
    .stable_o  (stable_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic en;
    logic set;
    logic rst_req;
    logic rise;
    logic conflict;
    logic stable;
  } exp_t;

  exp_t exp_q[$];
  int   checks   = 0;
  int   failures = 0;

  // Reference model: SW seen two edges late; a clean bit flips once the synced
  // bit has disagreed with it on D+1 consecutive edges.
  logic [2:0] hist_new, hist_old;
  logic [2:0] m_clean;
  int         m_run [3];
  logic       m_en_prev, m_rise, m_sticky;

  always @(posedge clk) begin
    exp_t       e;
    logic [2:0] old_clean;
    logic       any_pend;
    if (rst) begin
      hist_new = '0; hist_old = '0; m_clean = '0;
      for (int i = 0; i < 3; i++) m_run[i] = 0;
      m_en_prev = 0; m_rise = 0; m_sticky = 0;
    end else begin
      old_clean = m_clean;
      m_rise    = old_clean[2] && !m_en_prev;
      m_en_prev = old_clean[2];
      if (old_clean == 3'b111) m_sticky = 1;
      for (int i = 0; i < 3; i++) begin
        if (hist_old[i] != old_clean[i]) begin
          m_run[i]++;
          if (m_run[i] == D + 1) begin
            m_clean[i] = hist_old[i];
            m_run[i]   = 0;
          end
        end else begin
          m_run[i] = 0;
        end
      end
      hist_old = hist_new;
      hist_new = sw;
    end
    any_pend   = (m_run[0] != 0) || (m_run[1] != 0) || (m_run[2] != 0);
    e.en       = m_clean[2];
    e.set      = m_clean[2] && m_clean[0] && !m_clean[1];
    e.rst_req  = m_clean[2] && m_clean[1] && !m_clean[0];
    e.rise     = m_rise;
`ifdef SRC_STICKY_CONFLICT_EN
    e.conflict = m_sticky || (m_clean == 3'b111);
`else
    e.conflict = (m_clean == 3'b111);
`endif
    e.stable   = !any_pend;
    exp_q.push_back(e);
  end

  task automatic chk(input string name, input logic act, input logic exp_v);
    checks++;
    if (act !== exp_v) begin
      failures++;
      $display("FAIL %s at %0t: got %b expected %b", name, $time, act, exp_v);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk("en_o",       en_o,       e.en);
      chk("set_o",      set_o,      e.set);
      chk("reset_o",    reset_o,    e.rst_req);
      chk("en_rise_o",  en_rise_o,  e.rise);
      chk("conflict_o", conflict_o, e.conflict);
      chk("stable_o",   stable_o,   e.stable);
    end
  end

  task automatic step(input logic [2:0] v, input logic r, input int n);
    sw  = v;
    rst = r;
    repeat (n) @(negedge clk);
  endtask

  initial begin
    sw  = '0;
    rst = 1'b1;
    @(negedge clk);
    step(3'b000, 1, 3);
    // enable + set held
    step(3'b101, 0, 12);
    // short S glitch while enabled
    step(3'b100, 0, 10);
    step(3'b101, 0, 3);
    step(3'b100, 0, 12);
    // invalid S=R=1, then release R
    step(3'b111, 0, 10);
    step(3'b101, 0, 10);
    // reset in the middle of a debounce
    step(3'b000, 1, 2);
    step(3'b110, 0, 10);
    step(3'b101, 0, 3);
    step(3'b101, 1, 1);
    step(3'b101, 0, 12);
    // staggered bit changes
    step(3'b000, 1, 2);
    step(3'b001, 0, 2);
    step(3'b011, 0, 3);
    step(3'b111, 0, 1);
    step(3'b110, 0, 12);
    // random levels and hold lengths around the debounce window
    for (int k = 0; k < 300; k++) begin
      step(3'($urandom), ($urandom_range(0, 39) == 0), $urandom_range(1, 9));
    end
    step(3'b000, 0, 10);
    @(posedge clk);
    @(negedge clk);
    #1;
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
